// File: rtl/imem_sync_pkg.sv
// imem_sync_pkg: shared definitions for the synchronous instruction memory.
// Holds the response fault codes, the RISC-V NOP encoding, the controller
// state encoding and two small byte-lane helpers used for endianness mapping.
package imem_sync_pkg;

    // Fault codes reported on rsp_fault (2'b11 is never produced)
    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    // RISC-V canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_RV = 32'h0000_0013;

    // Controller states: CLEAR fills the array with NOPs after reset, RUN serves traffic
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Reverse the byte order of a 32-bit word
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Reverse a 4-bit byte-enable vector to follow a byte-swapped word
    function automatic logic [3:0] rev4(input logic [3:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/imem_sync_if.sv
// imem_sync_if: bus bundle between fetch/boot logic (master) and imem_sync (slave).
//   req_valid/req_ready/req_addr     : fetch request handshake, byte address
//   rsp_valid/rsp_ready/rsp_instr/rsp_fault : fetch response handshake
//   ld_en/ld_addr/ld_data/ld_be      : byte-enabled bootload write port
//   init_done                        : high once the post-reset clear has finished
interface imem_sync_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic [1:0]        rsp_fault;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic [3:0]        ld_be;
    logic              init_done;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, init_done
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, init_done
    );

endinterface

// File: rtl/imem_ram_be.sv
// imem_ram_be: single-port synchronous RAM, DEPTH x 32, four byte write enables
// and a registered read. The array and the read register have no reset.
//   i_clk   : clock
//   i_addr  : word address shared by read and write
//   i_we    : byte write enables, i_we[k] writes i_wdata[8k+7:8k]
//   i_wdata : write data
//   i_re    : read enable; o_rdata only changes on a read, so it can hold a response
//   o_rdata : registered read data
module imem_ram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane writes and the enabled registered read share the one address
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_sync.sv
// imem_sync: synchronous word-organised instruction memory for the fetch stage.
// After reset it writes NOP_WORD to every word (CLEAR), then serves 1-cycle
// latency fetches and byte-enabled bootloader writes (RUN).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : imem_sync_if slave modport (fetch request/response, load port, init_done)
// Storage keeps bytes in address order (lane k = byte at word base + k); the
// BIG_ENDIAN swap is applied on the way in and out so that load and fetch agree.
module imem_sync
    import imem_sync_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DEPTH      = 1024,
    parameter int          BIG_ENDIAN = 0,
    parameter logic [31:0] NOP_WORD   = NOP_RV
) (
    input  logic        clk,
    input  logic        rst,
    imem_sync_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_clr_cnt;
    logic [AW-1:0]     w_clr_cnt_next;

    logic              r_rsp_valid;
    logic [1:0]        r_rsp_fault;
    logic              r_rsp_ok;

    logic [ADDR_W-1:0] w_req_word;
    logic [ADDR_W-1:0] w_ld_word;
    logic              w_req_misalign;
    logic              w_req_oor;
    logic              w_ld_oor;
    logic [1:0]        w_req_fault;
    logic              w_req_ready;
    logic              w_accept;

    logic [AW-1:0]     w_ram_addr;
    logic [3:0]        w_ram_we;
    logic [31:0]       w_ram_wdata;
    logic              w_ram_re;
    logic [31:0]       w_ram_rdata;

    // Full word indices: range checks use every upper bit so nothing aliases
    assign w_req_word     = bus.req_addr >> 2;
    assign w_ld_word      = bus.ld_addr >> 2;
    assign w_req_misalign = |bus.req_addr[1:0];
    assign w_req_oor      = (w_req_word >= ADDR_W'(DEPTH));
    assign w_ld_oor       = (w_ld_word >= ADDR_W'(DEPTH));

    // Misalignment wins over range when both apply
    assign w_req_fault = w_req_misalign ? FAULT_MISALIGN :
                         w_req_oor      ? FAULT_RANGE    : FAULT_OK;

    // A load owns the RAM port this cycle, and a stalled response blocks new accepts
    assign w_req_ready = (r_state == RUN) && !bus.ld_en && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    // State and clear-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Next state and RAM port arbitration: the clear writer in CLEAR, then in RUN
    // either the load writer or the fetch reader (they never coincide)
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_ram_addr     = w_req_word[AW-1:0];
        w_ram_we       = 4'h0;
        w_ram_wdata    = 32'h0;
        w_ram_re       = 1'b0;
        case (r_state)
            CLEAR: begin
                w_ram_addr     = r_clr_cnt;
                w_ram_we       = 4'hF;
                w_ram_wdata    = (BIG_ENDIAN != 0) ? bswap32(NOP_WORD) : NOP_WORD;
                w_clr_cnt_next = r_clr_cnt + AW'(1);
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.ld_en) begin
                    if (!w_ld_oor) begin
                        w_ram_addr  = w_ld_word[AW-1:0];
                        w_ram_we    = (BIG_ENDIAN != 0) ? rev4(bus.ld_be) : bus.ld_be;
                        w_ram_wdata = (BIG_ENDIAN != 0) ? bswap32(bus.ld_data) : bus.ld_data;
                    end
                end else if (w_accept && (w_req_fault == FAULT_OK)) begin
                    w_ram_re = 1'b1;
                end
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // Response tracking: r_rsp_ok marks that the RAM read register holds this
    // response's data, otherwise the instruction output is forced to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= FAULT_OK;
            r_rsp_ok    <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_req_fault;
            r_rsp_ok    <= (w_req_fault == FAULT_OK);
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    imem_ram_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .o_rdata (w_ram_rdata)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.rsp_instr = r_rsp_ok ? ((BIG_ENDIAN != 0) ? bswap32(w_ram_rdata) : w_ram_rdata)
                                    : 32'h0;
    assign bus.init_done = (r_state == RUN);

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: drives a little-endian and a big-endian imem_sync (DEPTH=16)
// with identical directed vectors; both must present identical responses.
// Inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_imem_sync;
    import imem_sync_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;
    localparam int NVEC   = 18;

    typedef struct {
        logic        reqValid;
        logic [31:0] reqAddr;
        logic        rspReady;
        logic        ldEn;
        logic [31:0] ldAddr;
        logic [31:0] ldData;
        logic [3:0]  ldBe;
        logic        expReady;
        logic        expValid;
        logic [31:0] expInstr;
        logic [1:0]  expFault;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    imem_sync_if #(.ADDR_W(ADDR_W)) busLe ();
    imem_sync_if #(.ADDR_W(ADDR_W)) busBe ();

    imem_sync #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(0), .NOP_WORD(NOP_RV)) dutLe (
        .clk (clk),
        .rst (rst),
        .bus (busLe)
    );

    imem_sync #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(1), .NOP_WORD(NOP_RV)) dutBe (
        .clk (clk),
        .rst (rst),
        .bus (busBe)
    );

    function automatic vec_t mkVec(input logic rv, input logic [31:0] ra, input logic rr,
                                   input logic le, input logic [31:0] la, input logic [31:0] ld,
                                   input logic [3:0] lb, input logic er, input logic ev,
                                   input logic [31:0] ei, input logic [1:0] ef);
        vec_t v;
        v.reqValid = rv; v.reqAddr = ra; v.rspReady = rr;
        v.ldEn = le; v.ldAddr = la; v.ldData = ld; v.ldBe = lb;
        v.expReady = er; v.expValid = ev; v.expInstr = ei; v.expFault = ef;
        return v;
    endfunction

    task automatic checkVal(input string what, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        busLe.req_valid = v.reqValid; busBe.req_valid = v.reqValid;
        busLe.req_addr  = v.reqAddr;  busBe.req_addr  = v.reqAddr;
        busLe.rsp_ready = v.rspReady; busBe.rsp_ready = v.rspReady;
        busLe.ld_en     = v.ldEn;     busBe.ld_en     = v.ldEn;
        busLe.ld_addr   = v.ldAddr;   busBe.ld_addr   = v.ldAddr;
        busLe.ld_data   = v.ldData;   busBe.ld_data   = v.ldData;
        busLe.ld_be     = v.ldBe;     busBe.ld_be     = v.ldBe;
    endtask

    task automatic checkDut(input string tag, input logic rdy, input logic vld,
                            input logic [31:0] ins, input logic [1:0] flt, input vec_t v);
        checkVal({tag, ".req_ready"}, 32'(rdy), 32'(v.expReady));
        checkVal({tag, ".rsp_valid"}, 32'(vld), 32'(v.expValid));
        if (v.expValid) begin
            checkVal({tag, ".rsp_instr"}, ins, v.expInstr);
            checkVal({tag, ".rsp_fault"}, 32'(flt), 32'(v.expFault));
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkDut({tag, ".le"}, busLe.req_ready, busLe.rsp_valid, busLe.rsp_instr, busLe.rsp_fault, v);
        checkDut({tag, ".be"}, busBe.req_ready, busBe.rsp_valid, busBe.rsp_instr, busBe.rsp_fault, v);
    endtask

    // One cycle: drive at the falling edge, check, then move to the next falling edge
    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        #1;
        checkOutput(tag, v);
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, ".le.rsp_valid"}, 32'(busLe.rsp_valid), 32'h0);
        checkVal({tag, ".le.rsp_instr"}, busLe.rsp_instr, 32'h0);
        checkVal({tag, ".le.rsp_fault"}, 32'(busLe.rsp_fault), 32'h0);
        checkVal({tag, ".le.init_done"}, 32'(busLe.init_done), 32'h0);
        checkVal({tag, ".le.req_ready"}, 32'(busLe.req_ready), 32'h0);
        checkVal({tag, ".be.rsp_valid"}, 32'(busBe.rsp_valid), 32'h0);
        checkVal({tag, ".be.rsp_instr"}, busBe.rsp_instr, 32'h0);
        checkVal({tag, ".be.rsp_fault"}, 32'(busBe.rsp_fault), 32'h0);
        checkVal({tag, ".be.init_done"}, 32'(busBe.init_done), 32'h0);
        checkVal({tag, ".be.req_ready"}, 32'(busBe.req_ready), 32'h0);
    endtask

    // Called at a falling edge with rst high; CLEAR must take exactly DEPTH cycles
    task automatic runClear(input string tag);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checkVal($sformatf("%s.clear%0d.le.req_ready", tag, i), 32'(busLe.req_ready), 32'h0);
            checkVal($sformatf("%s.clear%0d.be.req_ready", tag, i), 32'(busBe.req_ready), 32'h0);
            checkVal($sformatf("%s.clear%0d.le.init_done", tag, i), 32'(busLe.init_done), 32'h0);
            checkVal($sformatf("%s.clear%0d.be.init_done", tag, i), 32'(busBe.init_done), 32'h0);
            @(negedge clk);
        end
        #1;
        checkVal({tag, ".done.le.init_done"}, 32'(busLe.init_done), 32'h1);
        checkVal({tag, ".done.be.init_done"}, 32'(busBe.init_done), 32'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: no finish by time 100000 (limit 100000)");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Memory after clear: every word 0x00000013; loads below update words 1, 2, 3
        tbl[0]  = mkVec(1, 32'h0000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 0, 32'h0,         FAULT_OK);
        tbl[1]  = mkVec(0, 32'h0000_0000, 1, 1, 32'h4, 32'h00A0_0093, 4'hF, 0, 1, 32'h0000_0013, FAULT_OK);
        tbl[2]  = mkVec(1, 32'h0000_0004, 1, 0, 32'h0, 32'h0, 4'h0,        1, 0, 32'h0,         FAULT_OK);
        tbl[3]  = mkVec(0, 32'h0000_0000, 1, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h00A0_0093, FAULT_OK);
        tbl[4]  = mkVec(0, 32'h0000_0000, 1, 1, 32'h8, 32'h0000_0011, 4'h1, 0, 0, 32'h0,         FAULT_OK);
        tbl[5]  = mkVec(1, 32'h0000_0008, 1, 0, 32'h0, 32'h0, 4'h0,        1, 0, 32'h0,         FAULT_OK);
        tbl[6]  = mkVec(1, 32'h0000_0006, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'hDEAD_BE11, FAULT_OK);
        tbl[7]  = mkVec(1, 32'h0000_0040, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0,         FAULT_MISALIGN);
        tbl[8]  = mkVec(1, 32'h0000_0042, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0,         FAULT_RANGE);
        tbl[9]  = mkVec(1, 32'h0000_003C, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0,         FAULT_MISALIGN);
        tbl[10] = mkVec(1, 32'h1000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0000_0013, FAULT_OK);
        tbl[11] = mkVec(0, 32'h0000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0,         FAULT_RANGE);
        tbl[12] = mkVec(0, 32'h0000_0000, 1, 1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0,       FAULT_OK);
        tbl[13] = mkVec(1, 32'h0000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 0, 32'h0,         FAULT_OK);
        tbl[14] = mkVec(0, 32'h0000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h0000_0013, FAULT_OK);
        tbl[15] = mkVec(0, 32'h0000_0000, 1, 1, 32'hC, 32'hAABB_CCDD, 4'h6, 0, 0, 32'h0,        FAULT_OK);
        tbl[16] = mkVec(1, 32'h0000_000C, 1, 0, 32'h0, 32'h0, 4'h0,        1, 0, 32'h0,         FAULT_OK);
        tbl[17] = mkVec(0, 32'h0000_0000, 1, 0, 32'h0, 32'h0, 4'h0,        1, 1, 32'h00BB_CC13, FAULT_OK);

        // Power-on reset with a fetch already requested
        rst = 1'b0;
        applyStimulus(mkVec(1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, FAULT_OK));
        #2 rst = 1'b1;
        #2 checkReset("reset");
        @(negedge clk);
        runClear("clear");

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Back-to-back fetches 0x0, 0x4, 0x8 with a stall while the second is held,
        // and a load to word 3 issued during the stall
        step("b2b0", mkVec(1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0,         1, 0, 32'h0,         FAULT_OK));
        step("b2b1", mkVec(1, 32'h4, 1, 0, 32'h0, 32'h0, 4'h0,         1, 1, 32'h0000_0013, FAULT_OK));
        step("b2b2", mkVec(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0,         0, 1, 32'h00A0_0093, FAULT_OK));
        step("b2b3", mkVec(1, 32'h8, 0, 1, 32'hC, 32'h1234_5678, 4'hF, 0, 1, 32'h00A0_0093, FAULT_OK));
        step("b2b4", mkVec(1, 32'h8, 1, 0, 32'h0, 32'h0, 4'h0,         1, 1, 32'h00A0_0093, FAULT_OK));
        step("b2b5", mkVec(0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0,         1, 1, 32'hDEAD_BE11, FAULT_OK));
        step("b2b6", mkVec(1, 32'hC, 1, 0, 32'h0, 32'h0, 4'h0,         1, 0, 32'h0,         FAULT_OK));
        step("b2b7", mkVec(0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0,         1, 1, 32'h1234_5678, FAULT_OK));
        step("b2b8", mkVec(1, 32'h8, 1, 0, 32'h0, 32'h0, 4'h0,         1, 0, 32'h0,         FAULT_OK));

        // Reset mid-cycle while a response is pending
        applyStimulus(mkVec(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hDEAD_BE11, FAULT_OK));
        #1 checkOutput("midrst.pre", mkVec(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hDEAD_BE11, FAULT_OK));
        #2 rst = 1'b1;
        #1 checkReset("midrst");
        applyStimulus(mkVec(1, 32'h8, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, FAULT_OK));
        @(negedge clk);
        runClear("reclear");
        step("reread0", mkVec(1, 32'h8, 1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0,         FAULT_OK));
        step("reread1", mkVec(0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h0000_0013, FAULT_OK));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
